// File: rtl/lru_tracker_n.sv
// lru_tracker_n
// True-LRU replacement tracker for a set-associative cache. Each set keeps one
// age per way: age 0 is the most recently used way and age NUM_WAYS-1 is the
// least recently used way. Within a set the ages always form a permutation of
// 0..NUM_WAYS-1.
//
// Ports:
//   clk, rst                   clock and synchronous active-high reset
//   touch_valid/set/way        hit or fill; the touched way becomes MRU
//   inv_valid/set/way          invalidate; the way becomes LRU
//   flush                      return every set to the reset ordering
//   lookup_set                 set whose victim is reported
//   victim_way, victim_oh      LRU way of lookup_set (encoded and one-hot),
//                              combinational from the current state
module lru_tracker_n #(
  parameter int NUM_WAYS = 4,
  parameter int NUM_SETS = 8,
  localparam int WAY_W = $clog2(NUM_WAYS),
  localparam int SET_W = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                touch_valid,
  input  logic [SET_W-1:0]    touch_set,
  input  logic [WAY_W-1:0]    touch_way,
  input  logic                inv_valid,
  input  logic [SET_W-1:0]    inv_set,
  input  logic [WAY_W-1:0]    inv_way,
  input  logic                flush,
  input  logic [SET_W-1:0]    lookup_set,
  output logic [WAY_W-1:0]    victim_way,
  output logic [NUM_WAYS-1:0] victim_oh
);

  localparam logic [WAY_W-1:0] AGE_LRU = WAY_W'(NUM_WAYS - 1);

  logic [WAY_W-1:0] ages_reg    [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0] ages_next   [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0] touch_age;
  logic [WAY_W-1:0] inv_age;
  logic [WAY_W-1:0] lookup_ages [NUM_WAYS];

  // Old age of the touched and invalidated ways; each update rule is
  // expressed relative to that age.
  always_comb begin
    touch_age = '0;
    inv_age   = '0;
    for (int s = 0; s < NUM_SETS; s++) begin
      if (touch_set == SET_W'(s)) touch_age = ages_reg[s][touch_way];
      if (inv_set == SET_W'(s))   inv_age   = ages_reg[s][inv_way];
    end
  end

  // Next-state ages. Flush beats everything; within one set an invalidate
  // beats a touch, while updates to two different sets proceed together.
  always_comb begin
    ages_next = ages_reg;
    for (int s = 0; s < NUM_SETS; s++) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (flush) begin
          ages_next[s][w] = WAY_W'(NUM_WAYS - 1 - w);
        end else if (inv_valid && inv_set == SET_W'(s)) begin
          // Ways younger than... older than the invalidated one move up by one
          // to close the gap it leaves.
          if (inv_way == WAY_W'(w))
            ages_next[s][w] = AGE_LRU;
          else if (ages_reg[s][w] > inv_age)
            ages_next[s][w] = ages_reg[s][w] - WAY_W'(1);
        end else if (touch_valid && touch_set == SET_W'(s)) begin
          // Ways more recent than the touched one age by one step.
          if (touch_way == WAY_W'(w))
            ages_next[s][w] = '0;
          else if (ages_reg[s][w] < touch_age)
            ages_next[s][w] = ages_reg[s][w] + WAY_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++)
          ages_reg[s][w] <= WAY_W'(NUM_WAYS - 1 - w);
    end else begin
      ages_reg <= ages_next;
    end
  end

  // Lookup reads the registered state only, so an update in flight this
  // cycle is visible on the following cycle.
  always_comb begin
    for (int w = 0; w < NUM_WAYS; w++) lookup_ages[w] = '0;
    for (int s = 0; s < NUM_SETS; s++)
      if (lookup_set == SET_W'(s))
        for (int w = 0; w < NUM_WAYS; w++) lookup_ages[w] = ages_reg[s][w];
  end

  generate
    for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_victim_oh
      assign victim_oh[gi] = (lookup_ages[gi] == AGE_LRU);
    end
  endgenerate

  always_comb begin
    victim_way = '0;
    for (int w = 0; w < NUM_WAYS; w++)
      if (lookup_ages[w] == AGE_LRU) victim_way = WAY_W'(w);
  end

endmodule

// File: tb/tb_lru_tracker_n.sv
// Testbench for lru_tracker_n: directed scenarios plus a randomised run,
// checked through a scoreboard against a recency-list reference model.
module tb_lru_tracker_n;
  localparam int NW = 4;
  localparam int NS = 8;
  localparam int WW = 2;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          touch_valid = 1'b0;
  logic [SW-1:0] touch_set = '0;
  logic [WW-1:0] touch_way = '0;
  logic          inv_valid = 1'b0;
  logic [SW-1:0] inv_set = '0;
  logic [WW-1:0] inv_way = '0;
  logic          flush = 1'b0;
  logic [SW-1:0] lookup_set = '0;
  logic [WW-1:0] victim_way;
  logic [NW-1:0] victim_oh;

  always #5 clk = ~clk;

  lru_tracker_n #(.NUM_WAYS(NW), .NUM_SETS(NS)) dut (
    .clk(clk), .rst(rst),
    .touch_valid(touch_valid), .touch_set(touch_set), .touch_way(touch_way),
    .inv_valid(inv_valid), .inv_set(inv_set), .inv_way(inv_way),
    .flush(flush), .lookup_set(lookup_set),
    .victim_way(victim_way), .victim_oh(victim_oh)
  );

  // Reference model: per set, the ways listed from most to least recently
  // used. The victim is the last entry.
  int order [NS][NW];
  int checks = 0;
  int failures = 0;
  bit done = 1'b0;

  typedef struct {
    int    set;
    int    way;
    string tag;
    bit    verbose;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [NW-1:0] mon_oh;

  function automatic void model_reset();
    // Way NW-1 is MRU and way 0 is LRU after reset.
    for (int s = 0; s < NS; s++)
      for (int p = 0; p < NW; p++) order[s][p] = NW - 1 - p;
  endfunction

  function automatic int find_pos(int s, int w);
    for (int p = 0; p < NW; p++) if (order[s][p] == w) return p;
    return 0;
  endfunction

  function automatic void move_front(int s, int w);
    int p = find_pos(s, w);
    for (int i = p; i > 0; i--) order[s][i] = order[s][i-1];
    order[s][0] = w;
  endfunction

  function automatic void move_back(int s, int w);
    int p = find_pos(s, w);
    for (int i = p; i < NW - 1; i++) order[s][i] = order[s][i+1];
    order[s][NW-1] = w;
  endfunction

  // One clock cycle: drive inputs, queue the pre-edge victim if requested,
  // then advance the model across the edge.
  task automatic step(input int tv, input int ts, input int tw,
                      input int iv, input int is, input int iw,
                      input int fl, input int rs, input int ls,
                      input bit chk, input string tag, input bit verbose);
    exp_t e;
    touch_valid = (tv != 0);
    touch_set   = SW'(ts);
    touch_way   = WW'(tw);
    inv_valid   = (iv != 0);
    inv_set     = SW'(is);
    inv_way     = WW'(iw);
    flush       = (fl != 0);
    rst         = (rs != 0);
    lookup_set  = SW'(ls);
    if (chk) begin
      e.set = ls; e.way = order[ls][NW-1]; e.tag = tag; e.verbose = verbose;
      exp_q.push_back(e);
    end
    @(posedge clk);
    if (rs != 0 || fl != 0) begin
      model_reset();
    end else begin
      if (iv != 0) move_back(is, iw);
      if (tv != 0 && !(iv != 0 && is == ts)) move_front(ts, tw);
    end
    #1;
  endtask

  task automatic idle_check(input int ls, input string tag);
    step(0, 0, 0, 0, 0, 0, 0, 0, ls, 1'b1, tag, 1'b1);
  endtask

  task automatic sweep(input string tag);
    for (int s = 0; s < NS; s++) idle_check(s, tag);
  endtask

  task automatic check_reset_state();
    rst         = 1'b0;
    touch_valid = 1'b0;
    inv_valid   = 1'b0;
    flush       = 1'b0;
    for (int s = 0; s < NS; s++) begin
      lookup_set = SW'(s);
      #1;
      checks++;
      if (victim_way !== WW'(0) || victim_oh !== NW'(1)) begin
        failures++;
        $display("FAIL reset_state set=%0d got way=%0d oh=%b expected way=0 oh=%b",
                 s, victim_way, victim_oh, NW'(1));
      end else begin
        $display("ok   reset_state set=%0d way=%0d oh=%b", s, victim_way, victim_oh);
      end
    end
  endtask

  task automatic random_ops(input int n, input bit allow_ctl, input string tag);
    for (int i = 0; i < n; i++) begin
      int fl = 0;
      int rs = 0;
      if (allow_ctl) begin
        fl = ($urandom_range(0, 199) == 0) ? 1 : 0;
        rs = ($urandom_range(0, 499) == 0) ? 1 : 0;
      end
      step($urandom_range(0, 1), $urandom_range(0, NS-1), $urandom_range(0, NW-1),
           ($urandom_range(0, 2) == 0) ? 1 : 0, $urandom_range(0, NS-1),
           $urandom_range(0, NW-1), fl, rs, $urandom_range(0, NS-1),
           1'b1, tag, 1'b0);
    end
  endtask

  // Monitor: outputs are combinational, so each cycle's expectations are
  // compared mid-cycle once the driven inputs have settled.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_oh = '0;
      mon_oh[mon_e.way] = 1'b1;
      checks++;
      if (victim_way !== WW'(mon_e.way) || victim_oh !== mon_oh) begin
        failures++;
        $display("FAIL %s set=%0d got way=%0d oh=%b expected way=%0d oh=%b",
                 mon_e.tag, mon_e.set, victim_way, victim_oh, mon_e.way, mon_oh);
      end else if (mon_e.verbose) begin
        $display("ok   %s set=%0d way=%0d oh=%b", mon_e.tag, mon_e.set,
                 victim_way, victim_oh);
      end
    end
  end

  // Watchdog: the stimulus must finish within a bounded wait.
  initial begin
    fork
      wait (done);
      #5ms;
    join_any
    disable fork;
    if (!done) begin
      failures++;
      $display("FAIL timeout waiting for stimulus to finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    // Reset for two cycles, then every set reports way 0.
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1'b0, "rst", 1'b0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1'b0, "rst", 1'b0);
    check_reset_state();
    sweep("reset_sweep");

    // Touch order in set 3 while set 2 stays untouched.
    for (int w = 0; w < 3; w++)
      step(1, 3, w, 0, 0, 0, 0, 0, 2, 1'b1, "touch_set2_idle", 1'b1);
    idle_check(3, "touch_order");
    // No bypass: touching the current victim still shows it this cycle.
    step(1, 3, 3, 0, 0, 0, 0, 0, 3, 1'b1, "no_bypass_old", 1'b1);
    idle_check(3, "no_bypass_new");
    idle_check(2, "set2_untouched");

    // Invalidate in set 5.
    for (int w = 0; w < 4; w++)
      step(1, 5, w, 0, 0, 0, 0, 0, 5, 1'b0, "", 1'b0);
    step(0, 0, 0, 1, 5, 2, 0, 0, 5, 1'b0, "", 1'b0);
    idle_check(5, "invalidate");
    step(1, 5, 2, 0, 0, 0, 0, 0, 5, 1'b0, "", 1'b0);
    idle_check(5, "touch_after_inv");

    // Simultaneous events on different sets, then on the same set.
    step(1, 1, 0, 1, 4, 3, 0, 0, 1, 1'b0, "", 1'b0);
    idle_check(1, "dual_touch_set1");
    idle_check(4, "dual_inv_set4");
    step(1, 6, 1, 1, 6, 1, 0, 0, 6, 1'b0, "", 1'b0);
    idle_check(6, "same_set_inv_wins");

    // Flush with a concurrent touch.
    random_ops(200, 1'b0, "rand_pre_flush");
    step(1, $urandom_range(0, NS-1), $urandom_range(0, NW-1), 0, 0, 0, 1, 0, 0,
         1'b0, "", 1'b0);
    sweep("flush_sweep");

    // Reset together with flush and touch.
    random_ops(200, 1'b0, "rand_pre_rst");
    step(1, 2, 1, 1, 3, 0, 1, 1, 0, 1'b0, "", 1'b0);
    sweep("rst_sweep");

    // Long randomised run including occasional flush and reset.
    random_ops(10000, 1'b1, "random");

    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, "", 1'b0);
    @(negedge clk);
    #1;
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
